// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the MEM-stage memory responders.
package mem_if_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int WORD_BYTES = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/latency_counter.sv
// Load/decrement wait-state counter; done while the count sits at zero.
module latency_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       done
);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = load_val;
    else if (dec && cnt_q != '0)  cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign done = (cnt_q == '0);
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding word request, LATENCY wait states,
// registered response, and a combinational stall for the pipeline.
module dmem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);
  localparam int         IDXW     = clog2(DEPTH_WORDS);
  localparam logic [3:0] LOAD_VAL = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH_WORDS];

  state_e          state_q, state_d;
  logic [31:0]     lat_rdata_q, lat_rdata_d;
  logic            lat_err_q, lat_err_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            accept, misaligned, cnt_done;
  logic [IDXW-1:0] idx;
  logic            unused_addr_bits;

  // Upper address bits are dropped so out-of-range addresses wrap.
  assign idx              = req_addr[IDXW+1:2];
  assign unused_addr_bits = ^req_addr[31:IDXW+2];
  assign misaligned       = (req_addr[1:0] != 2'b00);
  assign accept           = (state_q == IDLE) && req_valid;

  latency_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .load     (accept),
    .load_val (LOAD_VAL),
    .dec      (state_q == WAIT),
    .done     (cnt_done)
  );

  always_comb begin
    state_d     = state_q;
    lat_rdata_d = lat_rdata_q;
    lat_err_d   = lat_err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        // Load data is sampled at acceptance; the store lands on the same edge.
        lat_err_d   = misaligned;
        lat_rdata_d = (!req_write && !misaligned) ? mem[idx] : '0;
        state_d     = (LATENCY == 0) ? RESP : WAIT;
      end
      WAIT:    if (cnt_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    if (state_d == RESP) begin
      rsp_rdata_d = lat_rdata_d;
      rsp_err_d   = lat_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      lat_rdata_q <= '0;
      lat_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_rdata_q <= lat_rdata_d;
      lat_err_q   <= lat_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end

  // Array is never reset so stores survive a reset pulse.
  always_ff @(posedge clk)
    if (accept && req_write && !misaligned) mem[idx] <= req_wdata;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign stall     = req_valid && (state_q != RESP);
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined MIPS core: the target side of the MEM-stage load/store interface.
- Accepts one word request at a time and inserts LATENCY programmable wait states.
- Returns read data or a store acknowledgement, and drives `stall` so the pipeline holds MEM/WB until the response arrives.
- Sits beside the datapath at top level and replaces the zero-wait combinational data memory.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..4096.
- LATENCY, 2, wait states between acceptance and response; range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage presents a load or store.
- req_write  in  1  1 = store (memWrite), 0 = load.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_valid  out  1  one-cycle pulse; response for the accepted request.
- rsp_rdata  out  32  load data, valid while rsp_valid is high; 0 for stores and errors.
- rsp_err  out  1  misaligned access; valid while rsp_valid is high.
- stall  out  1  hold PC/IF/ID/EX/MEM registers.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0, latched request cleared.
  - Memory array is not reset; contents persist across reset.
- Reset mid-operation (in WAIT or RESP): the in-flight response is dropped. If that request was a store, it already committed at acceptance; do not roll it back.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On the edge with req_valid=1 the request is accepted.
    - Latch req_write, req_addr, req_wdata.
    - Store: write the array on this edge.
    - Load: capture rdata from the array (post-write contents are irrelevant, since only one request is in flight).
    - Next state: LATENCY=0 → RESP; otherwise WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0 → RESP.
  - RESP: rsp_valid=1 for exactly one cycle, req_ready=0, next state IDLE.
- Cycle counts:
  - Total latency from acceptance edge to the rsp_valid cycle is LATENCY+1 cycles.
  - Back-to-back requests are spaced at LATENCY+2 cycles.
- Request inputs are ignored outside IDLE. If req_valid drops during WAIT, the transaction still completes.
- Addressing:
  - Word index = req_addr[log2(DEPTH_WORDS)+1 : 2].
  - Upper address bits are ignored, so out-of-range addresses wrap modulo the depth.
- Misaligned access (req_addr[1:0] != 0):
  - Accepted normally and takes full latency.
  - No array write; rsp_rdata=0; rsp_err=1 in the RESP cycle.
- Store response: rsp_valid=1, rsp_rdata=0, rsp_err=0.
- stall is combinational: stall = req_valid && !(state==RESP).
  - The pipeline therefore advances in the RESP cycle.
  - A request with req_valid=1 in IDLE stalls in its acceptance cycle, including when LATENCY=0.
- Read-after-write to the same address in consecutive requests returns the new data.
- rsp_rdata and rsp_err are registered. Between responses they hold 0 (cleared in IDLE), not the last value.

Decomposition:
- Package mem_if_pkg:
  - FSM state enum {IDLE, WAIT, RESP}.
  - Constant WORD_BYTES=4.
  - Function clog2 for the index width.
- One sub-module, latency_counter:
  - Load/decrement 4-bit counter with a `done` output.
  - Reusable for the instruction-memory responder.

Test Plan:
- LATENCY=2, store 0xDEADBEEF @0x40, then load @0x40 → store rsp at cycle 3 after accept (rdata 0, err 0); load rsp rdata=0xDEADBEEF; stall high for 3 cycles per request.
- LATENCY=0, load @0x0 after reset with preloaded word 0x12345678 → rsp_valid on the cycle after acceptance; stall exactly 1 cycle.
- DEPTH_WORDS=256, store 0xA5A5A5A5 @0x400, load @0x0 → rdata=0xA5A5A5A5 (address wrap).
- Store 0x11111111 @0x42 → rsp_err=1, rdata 0; subsequent load @0x40 returns the prior contents unchanged.
- Accept a load, then drop req_valid and toggle req_addr during WAIT → response still arrives at LATENCY+1 cycles with data of the latched address; req_ready stays 0 until IDLE.
- Assert rst low while in WAIT after a store of 0x55 @0x8 → all outputs 0 immediately (async); after release, load @0x8 returns 0x55 and no stale rsp_valid appears.
